rst_req_gen: RTL and testbench

// - Source side of the programmable reset path: drives prog_rst_ni of the system reset manager.
// - Merges reset requests into one glitch-free, registered, minimum-width active-low pulse.

---
 rtl/rst_req_gen.sv | 122 ++++++++++++
 tb/tb_rst_req_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_req_gen.sv
// Programmable reset request source: merges SW, programmer and (with RST_REQ_WDOG_EN)
// watchdog requests into one registered, minimum-width active-low reset pulse plus quiet window.
module rst_req_gen #(
  parameter int unsigned ASSERT_CYCLES  = 16,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sw_req_i,
  input  logic       prog_req_i,
  input  logic       wdog_req_i,
  output logic       prog_rst_no,
  output logic       busy_o,
  output logic       rst_ack_o,
  output logic [2:0] cause_o
);

  localparam int unsigned MAX_CYCLES = (ASSERT_CYCLES > RELEASE_CYCLES) ? ASSERT_CYCLES
                                                                        : RELEASE_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] ASSERT_LOAD  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       pend_bits, pend_next;
  logic [2:0]       cause_next;
  logic [2:0]       req_bits;
  logic             prog_rst_next, busy_next, ack_next;
  logic             cnt_zero;
  logic             wdog_bit;

`ifdef RST_REQ_WDOG_EN
  assign wdog_bit = wdog_req_i;
`else
  // Watchdog input kept for port compatibility only; the constant source prunes all its logic.
  logic wdog_unused;
  assign wdog_unused = wdog_req_i;
  assign wdog_bit    = 1'b0;
`endif

  assign req_bits = {wdog_bit, prog_req_i, sw_req_i};
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_bits   <= '0;
      cause_o     <= '0;
      prog_rst_no <= 1'b1;
      busy_o      <= 1'b0;
      rst_ack_o   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pend_bits   <= pend_next;
      cause_o     <= cause_next;
      prog_rst_no <= prog_rst_next;
      busy_o      <= busy_next;
      rst_ack_o   <= ack_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|(req_bits | pend_bits)) state_next = ASSERT;
      ASSERT:  if (cnt_zero) state_next = prog_req_i ? HOLD : RELEASE;
      HOLD:    if (!prog_req_i) state_next = RELEASE;
      RELEASE: if (cnt_zero) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so the pulse is glitch-free.
  always_comb begin
    cnt_next   = cnt;
    pend_next  = pend_bits;
    cause_next = cause_o;
    ack_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (state_next == ASSERT) begin
          cnt_next   = ASSERT_LOAD;
          cause_next = req_bits | pend_bits;
          pend_next  = '0;
        end
      end
      ASSERT, HOLD: begin
        cause_next = cause_o | req_bits;
        if (state_next == RELEASE) cnt_next = RELEASE_LOAD;
        else if (!cnt_zero)        cnt_next = cnt - 1'b1;
      end
      RELEASE: begin
        pend_next = pend_bits | req_bits;
        if (!cnt_zero) cnt_next = cnt - 1'b1;
        ack_next  = cnt_zero;
      end
      default: ;
    endcase
    prog_rst_next = !((state_next == ASSERT) || (state_next == HOLD));
    busy_next     = (state_next != IDLE);
  end

`ifndef SYNTHESIS
  a_busy_tracks_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_o == (state != IDLE));
  a_low_tracks_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !prog_rst_no == ((state == ASSERT) || (state == HOLD)));
  a_ack_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rst_ack_o |-> (state == IDLE));
`endif

endmodule

// File: tb/tb_rst_req_gen.sv
// Self-checking bench for rst_req_gen: directed scenarios plus random traffic against a
// timeline model (low-cycle count / quiet countdown). Honours RST_REQ_WDOG_EN like the DUT.
module tb_rst_req_gen;

  localparam int A = 16;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_req = 1'b0, prog_req = 1'b0, wdog_req = 1'b0;
  logic       prog_rst_n, busy, ack;
  logic [2:0] cause;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit       m_low;
  int       m_lowcnt, m_quiet;
  logic [2:0] m_pend, m_cause;
  bit       m_ack;

  rst_req_gen #(.ASSERT_CYCLES(A), .RELEASE_CYCLES(R)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sw_req_i   (sw_req),
    .prog_req_i (prog_req),
    .wdog_req_i (wdog_req),
    .prog_rst_no(prog_rst_n),
    .busy_o     (busy),
    .rst_ack_o  (ack),
    .cause_o    (cause)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {prog_rst_n, busy, ack, cause};
  endfunction

  function automatic logic [5:0] expv();
    return {~m_low, (m_low || m_quiet > 0), m_ack, m_cause};
  endfunction

  task automatic m_reset();
    m_low = 0; m_lowcnt = 0; m_quiet = 0; m_pend = '0; m_cause = '0; m_ack = 0;
  endtask

  // One sampled clock edge in the model, with the inputs the DUT saw at that edge.
  task automatic m_edge(input logic s, input logic p, input logic w);
    logic [2:0] b;
`ifdef RST_REQ_WDOG_EN
    b = {w, p, s};
`else
    b = {1'b0, p, s};
`endif
    m_ack = 0;
    if (m_low) begin
      m_cause |= b;
      if (m_lowcnt >= A && !p) begin
        m_low = 0;
        m_quiet = R;
      end else m_lowcnt++;
    end else if (m_quiet > 0) begin
      m_pend |= b;
      m_quiet--;
      if (m_quiet == 0) m_ack = 1;
    end else if ((b | m_pend) != 3'b000) begin
      m_low = 1;
      m_lowcnt = 1;
      m_cause = b | m_pend;
      m_pend = '0;
    end
  endtask

  // Drive inputs, let the DUT and model take one edge, settle for sampling.
  task automatic step(input logic s, input logic p, input logic w);
    sw_req = s; prog_req = p; wdog_req = w;
    @(posedge clk);
    m_edge(s, p, w);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs() !== 6'b100000) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%b exp=100000", i, obs());
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sw_pulse();
    int lows = 0, ack_at = -1;
    for (int e = 1; e <= 24; e++) begin
      step(e == 1, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL sw_pulse e=%0d got=%b exp=%b", e, obs(), expv());
      end
      if (!prog_rst_n) lows++;
      if (ack && ack_at < 0) ack_at = e;
    end
    n_checks++;
    if (lows !== A || ack_at !== 21) begin
      n_fail++;
      $display("FAIL sw_pulse_timing low=%0d ack_at=%0d exp low=%0d ack_at=21", lows, ack_at, A);
    end
    n_checks++;
    if (cause !== 3'b001) begin
      n_fail++;
      $display("FAIL sw_cause got=%b exp=001", cause);
    end
  endtask

  task automatic test_prog_hold();
    int lows = 0, ack_at = -1;
    for (int e = 1; e <= 48; e++) begin
      step(1'b0, e <= 40, 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL prog_hold e=%0d got=%b exp=%b", e, obs(), expv());
      end
      if (!prog_rst_n) lows++;
      if (ack && ack_at < 0) ack_at = e;
    end
    n_checks++;
    if (lows !== 40 || ack_at !== 45 || cause !== 3'b010) begin
      n_fail++;
      $display("FAIL prog_hold_timing low=%0d ack_at=%0d cause=%b exp 40/45/010", lows, ack_at, cause);
    end
  endtask

  task automatic test_back_to_back();
    int lows = 0, ack_at = -1, second_start = -1;
    for (int e = 1; e <= 45; e++) begin
      step(e == 1 || e == 19, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL back_to_back e=%0d got=%b exp=%b", e, obs(), expv());
      end
      if (!prog_rst_n) lows++;
      if (ack && ack_at < 0) ack_at = e;
      if (e > 17 && !prog_rst_n && second_start < 0) second_start = e;
    end
    n_checks++;
    if (ack_at !== 21 || second_start !== 22 || lows !== 2 * A) begin
      n_fail++;
      $display("FAIL back_to_back_timing ack_at=%0d start2=%0d low=%0d exp 21/22/%0d",
               ack_at, second_start, lows, 2 * A);
    end
  endtask

  task automatic test_async_reset();
    int acks = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int e = 2; e <= 4; e++) step(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 6'b100000) begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=100000", obs());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
    for (int e = 0; e < 12; e++) begin
      step(1'b0, 1'b0, 1'b0);
      if (ack) acks++;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL post_reset_idle e=%0d got=%b exp=%b", e, obs(), expv());
      end
    end
    n_checks++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL async_reset_ack got=%0d exp=0", acks);
    end
  endtask

  task automatic test_wdog();
    logic [2:0] exp_cause;
    step(1'b1, 1'b0, 1'b1);
`ifdef RST_REQ_WDOG_EN
    exp_cause = 3'b101;
`else
    exp_cause = 3'b001;
`endif
    n_checks++;
    if (cause !== exp_cause || prog_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_merge cause=%b rst=%b exp cause=%b rst=0", cause, prog_rst_n, exp_cause);
    end
    for (int e = 2; e <= 24; e++) begin
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL wdog_seq e=%0d got=%b exp=%b", e, obs(), expv());
      end
    end
    // lone watchdog pulse
    step(1'b0, 1'b0, 1'b1);
    for (int e = 0; e < 3; e++) begin
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL wdog_alone e=%0d got=%b exp=%b", e, obs(), expv());
      end
      step(1'b0, 1'b0, 1'b0);
    end
`ifndef RST_REQ_WDOG_EN
    n_checks++;
    if (busy !== 1'b0 || prog_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_ignored busy=%b rst=%b exp busy=0 rst=1", busy, prog_rst_n);
    end
`endif
    for (int e = 0; e < 25; e++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic p = 1'b0;
    for (int e = 0; e < 1500; e++) begin
      if ($urandom_range(0, 19) == 0) p = ~p;
      step($urandom_range(0, 15) == 0, p, $urandom_range(0, 31) == 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random e=%0d got=%b exp=%b", e, obs(), expv());
      end
    end
    for (int e = 0; e < 40; e++) begin
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL drain e=%0d got=%b exp=%b", e, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_pulse();
    test_prog_hold();
    test_back_to_back();
    test_async_reset();
    test_wdog();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
